sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for the same-domain buffering paths in the transmit datapath. It sits where producer and consumer share one clock and no pointer synchronisation is needed. It adds the following to the dual-clock FIFO:
- Selectable first-word-fall-through (FWFT) read mode.
- Programmable almost-full/almost-empty thresholds.
- An exact fill level.
- Sticky overflow/underflow error flags.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_mem.sv | 32 +++
 rtl/sync_fifo.sv | 152 +++++++++++++++
 tb/tb_sync_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: depth derivation,
// read-mode encoding and the threshold legality rule.
package sync_fifo_pkg;

  // Read-mode encoding for the FWFT parameter.
  localparam int FWFT_OFF = 0;  // registered read, DOUT_VALID pulses
  localparam int FWFT_ON  = 1;  // head word presented combinationally

  // Number of storage locations for a given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Almost-full must lie in 1..depth, and almost-empty must sit strictly
  // below it so that the two flags describe a non-degenerate window.
  function automatic bit thresholds_legal(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= afull - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write, combinational read.
// The read port is asynchronous so the top level can either register it
// (standard mode) or present it directly (first-word-fall-through).
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 49,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  // Contents are deliberately not reset; the pointers define what is valid.
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  // Store the incoming word at the write address when the write is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable first-word-fall-through, programmable
// almost-full/almost-empty thresholds, exact fill level and sticky
// overflow/underflow flags. All status outputs decode the count register.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 49,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = FWFT_OFF,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  W_EN,
  input  logic                  R_EN,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  DOUT_VALID,
  output logic                  FULL_flag,
  output logic                  EMPTY_flag,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [ADDR_WIDTH:0]   empty_loc,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);

  // Refuse to build with an inconsistent threshold window or unknown mode.
  generate
    if (!thresholds_legal(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("sync_fifo: AFULL_THRESH must be 1..DEPTH and AEMPTY_THRESH 0..AFULL_THRESH-1");
    end
    if ((FWFT != FWFT_OFF) && (FWFT != FWFT_ON)) begin : g_bad_mode
      $error("sync_fifo: FWFT must be 0 or 1");
    end
  endgenerate

  // Pointers carry an extra wrap bit and roll over naturally.
  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Status flags come straight from the count register.
  assign EMPTY_flag   = (count_reg == '0);
  assign FULL_flag    = (count_reg == DEPTH_CNT);
  assign ALMOST_FULL  = (count_reg >= AFULL_CNT);
  assign ALMOST_EMPTY = (count_reg <= AEMPTY_CNT);
  assign fill_level   = count_reg;
  assign empty_loc    = DEPTH_CNT - count_reg;
  assign OVERFLOW     = overflow_reg;
  assign UNDERFLOW    = underflow_reg;

  // Acceptance uses the registered flags: a full FIFO never takes a write,
  // even when a read drains a slot on the same edge.
  assign wr_acc = W_EN & ~FULL_flag;
  assign rd_acc = R_EN & ~EMPTY_flag;

  // Advance pointers and track the number of stored words.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + CNT_ONE;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + CNT_ONE;
      end
      if (wr_acc && !rd_acc) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        count_reg <= count_reg - CNT_ONE;
      end
    end
  end

  // Sticky error flags; a new error on the clearing cycle keeps the flag set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (W_EN && FULL_flag) begin
        overflow_reg <= 1'b1;
      end else if (ERR_CLR) begin
        overflow_reg <= 1'b0;
      end
      if (R_EN && EMPTY_flag) begin
        underflow_reg <= 1'b1;
      end else if (ERR_CLR) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data (Data_in),
    .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is visible whenever something is stored; zeros when empty.
      assign Data_out   = EMPTY_flag ? '0 : mem_rd_data;
      assign DOUT_VALID = ~EMPTY_flag;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_out_reg;
      logic                  dout_valid_reg;

      // Capture the head word on an accepted read and pulse valid for one cycle.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          data_out_reg   <= '0;
          dout_valid_reg <= 1'b0;
        end else begin
          dout_valid_reg <= rd_acc;
          if (rd_acc) begin
            data_out_reg <= mem_rd_data;
          end
        end
      end

      assign Data_out   = data_out_reg;
      assign DOUT_VALID = dout_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read and one FWFT instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b;
  logic       full_a, full_b, empty_a, empty_b;
  logic       af_a, af_b, ae_a, ae_b;
  logic [2:0] fill_a, fill_b, eloc_a, eloc_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         ovf_m = 1'b0;
  bit         unf_m = 1'b0;
  logic [7:0] dout_a_m = 8'h00;
  bit         dv_a_m = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut_a (
    .CLK(clk), .RST(rst), .Data_in(din), .W_EN(w_en), .R_EN(r_en), .ERR_CLR(err_clr),
    .Data_out(dout_a), .DOUT_VALID(dv_a), .FULL_flag(full_a), .EMPTY_flag(empty_a),
    .ALMOST_FULL(af_a), .ALMOST_EMPTY(ae_a), .fill_level(fill_a), .empty_loc(eloc_a),
    .OVERFLOW(ovf_a), .UNDERFLOW(unf_a)
  );

  sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut_b (
    .CLK(clk), .RST(rst), .Data_in(din), .W_EN(w_en), .R_EN(r_en), .ERR_CLR(err_clr),
    .Data_out(dout_b), .DOUT_VALID(dv_b), .FULL_flag(full_b), .EMPTY_flag(empty_b),
    .ALMOST_FULL(af_b), .ALMOST_EMPTY(ae_b), .fill_level(fill_b), .empty_loc(eloc_b),
    .OVERFLOW(ovf_b), .UNDERFLOW(unf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances with the model.
  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    chk({ctx, ".fill_a"},   32'(fill_a),  32'(n));
    chk({ctx, ".fill_b"},   32'(fill_b),  32'(n));
    chk({ctx, ".eloc_a"},   32'(eloc_a),  32'(4 - n));
    chk({ctx, ".eloc_b"},   32'(eloc_b),  32'(4 - n));
    chk({ctx, ".full_a"},   32'(full_a),  32'(n == 4));
    chk({ctx, ".full_b"},   32'(full_b),  32'(n == 4));
    chk({ctx, ".empty_a"},  32'(empty_a), 32'(n == 0));
    chk({ctx, ".empty_b"},  32'(empty_b), 32'(n == 0));
    chk({ctx, ".afull_a"},  32'(af_a),    32'(n >= 3));
    chk({ctx, ".afull_b"},  32'(af_b),    32'(n >= 3));
    chk({ctx, ".aempty_a"}, 32'(ae_a),    32'(n <= 1));
    chk({ctx, ".aempty_b"}, 32'(ae_b),    32'(n <= 1));
    chk({ctx, ".ovf_a"},    32'(ovf_a),   32'(ovf_m));
    chk({ctx, ".ovf_b"},    32'(ovf_b),   32'(ovf_m));
    chk({ctx, ".unf_a"},    32'(unf_a),   32'(unf_m));
    chk({ctx, ".unf_b"},    32'(unf_b),   32'(unf_m));
    chk({ctx, ".dout_a"},   32'(dout_a),  32'(dout_a_m));
    chk({ctx, ".dv_a"},     32'(dv_a),    32'(dv_a_m));
    chk({ctx, ".dout_b"},   32'(dout_b),  (n != 0) ? 32'(q[0]) : 32'h0);
    chk({ctx, ".dv_b"},     32'(dv_b),    32'(n != 0));
    $display("txn %-10s w=%0d r=%0d clr=%0d din=%02h fill=%0d dout_a=%02h dv_a=%0d dout_b=%02h dv_b=%0d ovf=%0d unf=%0d",
             ctx, w_en, r_en, err_clr, din, fill_a, dout_a, dv_a, dout_b, dv_b, ovf_a, unf_a);
  endtask

  // Apply one cycle of stimulus, advance the model, then check.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit clr, input string ctx);
    bit full_m, empty_m, wacc, racc;
    w_en = w; din = d; r_en = r; err_clr = clr;
    @(posedge clk);
    full_m  = (q.size() == 4);
    empty_m = (q.size() == 0);
    wacc = w && !full_m;
    racc = r && !empty_m;
    dv_a_m = 1'b0;
    if (racc) begin
      dout_a_m = q.pop_front();
      dv_a_m = 1'b1;
    end
    if (wacc) q.push_back(d);
    if (w && full_m) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
    if (r && empty_m) unf_m = 1'b1; else if (clr) unf_m = 1'b0;
    #1;
    check_all(ctx);
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    dout_a_m = 8'h00;
    dv_a_m = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x11..0x44
    cycle(1, 8'h11, 0, 0, "fill1");
    cycle(1, 8'h22, 0, 0, "fill2");
    cycle(1, 8'h33, 0, 0, "fill3");
    cycle(1, 8'h44, 0, 0, "fill4");

    // Full boundary: read accepted, write of 0x55 refused
    cycle(1, 8'h55, 1, 0, "full_rw");
    cycle(0, 8'h00, 1, 0, "drain");

    // Wrap-around at fill level 2 with concurrent traffic
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(8'h80 + i), 1, 0, "wrap");
    end

    // Drain to empty, then read on empty
    cycle(0, 8'h00, 1, 0, "drain");
    cycle(0, 8'h00, 1, 0, "drain");
    cycle(0, 8'h00, 1, 0, "empty_rd");
    cycle(1, 8'hA5, 1, 0, "empty_rw");
    cycle(0, 8'h00, 0, 0, "hold");
    cycle(0, 8'h00, 0, 1, "err_clr");
    cycle(0, 8'h00, 1, 0, "pop_a5");
    cycle(0, 8'h00, 1, 1, "clr_vs_set");

    // Reset mid-operation with 3 words and an error flag set
    cycle(0, 8'h00, 0, 1, "err_clr");
    cycle(1, 8'h61, 0, 0, "mid_wr");
    cycle(1, 8'h62, 0, 0, "mid_wr");
    cycle(1, 8'h63, 0, 0, "mid_wr");
    cycle(1, 8'h64, 0, 0, "mid_wr");
    cycle(1, 8'h65, 0, 0, "mid_ovf");
    cycle(0, 8'h00, 1, 0, "mid_rd");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 8'h7E, 0, 0, "post_wr");
    cycle(1, 8'h7F, 0, 0, "post_wr");
    cycle(0, 8'h00, 1, 0, "post_rd");
    cycle(0, 8'h00, 1, 0, "post_rd");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 6, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
